// File: rtl/mul_div_ctrl.sv
// mul_div_ctrl: multi-cycle multiply/divide sequencer owning the HI/LO pair.
// MULT/MULTU/DIV/DIVU compute their 64-bit result at acceptance into a
// pending register, then hold busy for a fixed latency before committing
// {hi,lo} atomically. MTHI/MTLO write HI/LO directly in the accepting edge.
// Optional feature macro: MD_CANCEL_EN adds the `cancel` input, which aborts
// an in-flight op without committing it.
module mul_div_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef MD_CANCEL_EN
  input  logic        cancel,
`endif
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  // Counter reload values: the commit happens on the edge that sees cnt==0,
  // so loading N-1 gives exactly N busy cycles.
  localparam logic [4:0] MUL_LOAD = 5'(MUL_CYCLES - 1);
  localparam logic [4:0] DIV_LOAD = 5'(DIV_CYCLES - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state, state_nx;
  logic [4:0]  cnt, cnt_nx;
  logic [63:0] pend, pend_nx;
  logic [63:0] res;
  logic        busy_nx, done_nx;
  logic [31:0] hi_nx, lo_nx;
  logic        abort;
  logic        is_md;
  logic        accept;

  // Arithmetic operand views
  logic signed [63:0] sx_a, sx_b;
  logic signed [31:0] s_a, s_b;
  logic               div_ovf;

`ifdef MD_CANCEL_EN
  assign abort = cancel;
`else
  assign abort = 1'b0;
`endif

  // Opcodes 000..011 are the multi-cycle class; 1xx are moves or reserved.
  assign is_md  = ~op[2];
  assign accept = start && (state == S_IDLE);

  assign s_a     = A;
  assign s_b     = B;
  assign sx_a    = {{32{A[31]}}, A};
  assign sx_b    = {{32{B[31]}}, B};
  // The single signed quotient that does not fit in 32 bits.
  assign div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

  // Full 64-bit result of the requested op, formatted as {hi,lo}.
  always_comb begin
    res = '0;
    case (op)
      OP_MULT:  res = sx_a * sx_b;
      OP_MULTU: res = {32'd0, A} * {32'd0, B};
      OP_DIV: begin
        if (B == 32'd0)   res = {A, 32'hFFFF_FFFF};
        else if (div_ovf) res = {32'd0, 32'h8000_0000};
        else              res = {s_a % s_b, s_a / s_b};
      end
      OP_DIVU: begin
        if (B == 32'd0)   res = {A, 32'hFFFF_FFFF};
        else              res = {A % B, A / B};
      end
      default:            res = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state: leave IDLE only for a multi-cycle op; leave RUN on abort or
  // when the countdown reaches zero.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept && is_md)          state_nx = S_RUN;
      S_RUN:  if (abort || (cnt == 5'd0))   state_nx = S_IDLE;
      default:                              state_nx = S_IDLE;
    endcase
  end

  // Output/datapath next values: accept, count down, commit or drop.
  always_comb begin
    cnt_nx  = cnt;
    pend_nx = pend;
    busy_nx = busy;
    done_nx = 1'b0;
    hi_nx   = hi;
    lo_nx   = lo;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (op)
            OP_MTHI: hi_nx = A;
            OP_MTLO: lo_nx = A;
            OP_MULT, OP_MULTU: begin
              pend_nx = res;
              cnt_nx  = MUL_LOAD;
              busy_nx = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              pend_nx = res;
              cnt_nx  = DIV_LOAD;
              busy_nx = 1'b1;
            end
            default: ;  // reserved opcodes do nothing
          endcase
        end
      end
      S_RUN: begin
        if (abort) begin
          // Cancel wins over a same-edge commit; HI/LO stay untouched.
          busy_nx = 1'b0;
          cnt_nx  = 5'd0;
        end else if (cnt == 5'd0) begin
          {hi_nx, lo_nx} = pend;
          busy_nx        = 1'b0;
          done_nx        = 1'b1;
        end else begin
          cnt_nx = cnt - 5'd1;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and datapath state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= 5'd0;
      pend <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      hi   <= '0;
      lo   <= '0;
    end else begin
      cnt  <= cnt_nx;
      pend <= pend_nx;
      busy <= busy_nx;
      done <= done_nx;
      hi   <= hi_nx;
      lo   <= lo_nx;
    end
  end

endmodule

// File: tb/tb_mul_div_ctrl.sv
// tb_mul_div_ctrl: table vectors, hand sequences for start-hold, reset
// mid-op, single-cycle latency and (optionally) cancel, then random ops
// checked against a plain-arithmetic reference model.
module tb_mul_div_ctrl;
  localparam int MULN = 5;
  localparam int DIVN = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        start1 = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] A = '0, B = '0;
  logic        busy, done, busy1, done1;
  logic [31:0] hi, lo, hi1, lo1;
`ifdef MD_CANCEL_EN
  logic        cancel = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  logic [31:0] mhi = '0, mlo = '0;

  always #5 clk = ~clk;

  mul_div_ctrl #(.MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef MD_CANCEL_EN
    .cancel(cancel),
`endif
    .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // Second instance with single-cycle latency for the N=1 boundary.
  mul_div_ctrl #(.MUL_CYCLES(1), .DIV_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
`ifdef MD_CANCEL_EN
    .cancel(cancel),
`endif
    .start(start1), .op(op), .A(A), .B(B),
    .busy(busy1), .done(done1), .hi(hi1), .lo(lo1)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: MIPS HI/LO semantics from 64-bit integer arithmetic.
  function automatic void model(input logic [2:0] o, input logic [31:0] a, b,
                                input logic [31:0] ch, cl,
                                output logic [31:0] nh, output logic [31:0] nl);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    nh = ch; nl = cl;
    case (o)
      3'd0: begin q = sa * sb; nh = q[63:32]; nl = q[31:0]; end
      3'd1: begin up = ua * ub; nh = up[63:32]; nl = up[31:0]; end
      3'd2: if (b == 0) begin nh = a; nl = '1; end
            else begin q = sa / sb; r = sa % sb; nh = r[31:0]; nl = q[31:0]; end
      3'd3: if (b == 0) begin nh = a; nl = '1; end
            else begin uq = ua / ub; ur = ua % ub; nh = ur[31:0]; nl = uq[31:0]; end
      3'd4: nh = a;
      3'd5: nl = a;
      default: ;
    endcase
  endfunction

  // Issue one op, scramble inputs after acceptance, count busy cycles,
  // then check done, HI/LO and that done is a single pulse.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, b, eh, el, input string nm);
    int n, en;
    en = o[2] ? 0 : (o[1] ? DIVN : MULN);
    @(negedge clk); start = 1'b1; op = o; A = a; B = b;
    @(negedge clk); start = 1'b0; op = 3'($urandom); A = $urandom; B = $urandom;
    n = 0;
    while (busy && n < 64) begin n++; @(negedge clk); end
    check({nm, " busy_cycles"}, 64'(n), 64'(en));
    check({nm, " done"}, 64'(done), 64'(en != 0));
    check({nm, " hilo"}, {hi, lo}, {eh, el});
    @(negedge clk);
    check({nm, " done_single"}, 64'(done), 64'd0);
    mhi = eh; mlo = el;
  endtask

  initial begin
    vec_t vt[12];
    int n, seen;
    logic [31:0] eh, el;

    vt[0]  = '{3'd0, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vt[1]  = '{3'd1, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE};
    vt[2]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vt[3]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vt[4]  = '{3'd3, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF};
    vt[5]  = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vt[6]  = '{3'd4, 32'hDEAD_BEEF, 32'd9,         32'hDEAD_BEEF, 32'hFFFF_FFFD};
    vt[7]  = '{3'd5, 32'hCAFE_F00D, 32'd9,         32'hDEAD_BEEF, 32'hCAFE_F00D};
    vt[8]  = '{3'd6, 32'd1,         32'd2,         32'hDEAD_BEEF, 32'hCAFE_F00D};
    vt[9]  = '{3'd3, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E};
    vt[10] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vt[11] = '{3'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};

    // Asynchronous reset, checked before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hilo", {hi, lo}, 64'd0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, $sformatf("vec%0d", i));

    // start held high through RUN with MTLO, accepted in the done cycle.
    @(negedge clk); start = 1'b1; op = 3'd0; A = 32'h0001_0000; B = 32'h0003_0000;
    @(negedge clk); op = 3'd5; A = 32'h1234_5678;
    n = 0;
    while (busy && n < 64) begin n++; @(negedge clk); end
    check("hold busy_cycles", 64'(n), 64'(MULN));
    check("hold done", 64'(done), 64'd1);
    check("hold mult hilo", {hi, lo}, {32'd3, 32'd0});
    @(negedge clk); start = 1'b0;
    check("hold mtlo hilo", {hi, lo}, {32'd3, 32'h1234_5678});
    check("hold mtlo busy", 64'(busy), 64'd0);
    check("hold mtlo done", 64'(done), 64'd0);

    // Reset pulsed mid-DIV.
    @(negedge clk); start = 1'b1; op = 3'd2; A = 32'd100; B = 32'd3;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst hilo", {hi, lo}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("midrst quiet", 64'(seen), 64'd0);
    check("midrst hilo after", {hi, lo}, 64'd0);
    mhi = '0; mlo = '0;

    // Single-cycle latency instance.
    @(negedge clk); start1 = 1'b1; op = 3'd1; A = 32'd3; B = 32'd5;
    @(negedge clk); start1 = 1'b0;
    check("n1 busy", 64'(busy1), 64'd1);
    check("n1 no done yet", 64'(done1), 64'd0);
    @(negedge clk);
    check("n1 busy drop", 64'(busy1), 64'd0);
    check("n1 done", 64'(done1), 64'd1);
    check("n1 hilo", {hi1, lo1}, {32'd0, 32'd15});
    @(negedge clk);
    check("n1 done single", 64'(done1), 64'd0);

`ifdef MD_CANCEL_EN
    // Cancel after three busy cycles: no commit, no done.
    run_op(3'd4, 32'h1111_1111, 32'd0, 32'h1111_1111, mlo, "cx mthi");
    run_op(3'd5, 32'h2222_2222, 32'd0, 32'h1111_1111, 32'h2222_2222, "cx mtlo");
    @(negedge clk); start = 1'b1; op = 3'd0; A = 32'd7; B = 32'd9;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk); cancel = 1'b1;
    @(negedge clk); cancel = 1'b0;
    check("cancel busy", 64'(busy), 64'd0);
    check("cancel done", 64'(done), 64'd0);
    check("cancel hilo", {hi, lo}, {32'h1111_1111, 32'h2222_2222});
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("cancel no late done", 64'(seen), 64'd0);
    // Cancel in IDLE does not block a same-cycle start.
    @(negedge clk); cancel = 1'b1; start = 1'b1; op = 3'd4; A = 32'h3333_3333;
    @(negedge clk); cancel = 1'b0; start = 1'b0;
    check("cancel idle mthi", {hi, lo}, {32'h3333_3333, 32'h2222_2222});
    mhi = 32'h3333_3333; mlo = 32'h2222_2222;
`endif

    // Random ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  o;
      logic [31:0] a, b;
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      model(o, a, b, mhi, mlo, eh, el);
      run_op(o, a, b, eh, el, $sformatf("rand%0d op%0d", i, o));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
